// File: rtl/prach_hb_interp_if.sv
// Sample/sideband bundle for the PRACH half-band interpolator: input sample stream
// with dv/chn/sync, two polyphase output rails and the sticky channel-error flag.
interface prach_hb_interp_if;
  logic [31:0] din_dq;
  logic        din_dv;
  logic [7:0]  din_chn;
  logic        sync_in;
  logic [31:0] dout_dp1;
  logic [31:0] dout_dp2;
  logic        dout_dv;
  logic [7:0]  dout_chn;
  logic        sync_out;
  logic        err_chn;

  modport master (
    output din_dq, din_dv, din_chn, sync_in,
    input  dout_dp1, dout_dp2, dout_dv, dout_chn, sync_out, err_chn
  );

  modport slave (
    input  din_dq, din_dv, din_chn, sync_in,
    output dout_dp1, dout_dp2, dout_dv, dout_chn, sync_out, err_chn
  );
endinterface

// File: rtl/prach_hb_interp.sv
// Time-multiplexed complex half-band interpolate-by-2 (DUC path), 4-cycle pipeline.
// Optional zero-order-hold bypass enabled with macro PRACH_HB_INTERP_BYPASS_EN.
module prach_hb_interp #(
  parameter int unsigned        NUM_CHN = 8,
  parameter logic signed [17:0] COEFF0  = -18'sd768,
  parameter logic signed [17:0] COEFF1  = 18'sd3072,
  parameter logic signed [17:0] COEFF2  = -18'sd6144,
  parameter logic signed [17:0] COEFF3  = 18'sd36608
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef PRACH_HB_INTERP_BYPASS_EN
  input  logic             ctrl_bypass,
`endif
  prach_hb_interp_if.slave bus
);

  localparam logic signed [17:0] Coeff [4] = '{COEFF0, COEFF1, COEFF2, COEFF3};

  function automatic logic signed [16:0] sx17(input logic [15:0] v);
    return {v[15], v};
  endfunction

  logic bypass;
`ifdef PRACH_HB_INTERP_BYPASS_EN
  assign bypass = ctrl_bypass;
`else
  assign bypass = 1'b0;
`endif

  logic [31:0]        hist_q [NUM_CHN][7];
  logic [31:0]        tap    [8];
  logic               chn_ok;
  logic               accept;
  logic signed [16:0] pre_d  [2][4];
  logic signed [16:0] pre_q  [2][4];
  logic signed [34:0] prod_q [2][4];
  logic signed [36:0] acc_q  [2];
  logic signed [36:0] rnd    [2];
  logic [15:0]        sat    [2];
  logic [31:0]        dp1_q  [3];
  logic [31:0]        dp1_out_q, dp2_out_q;
  logic               v_q    [4];
  logic               sync_q [4];
  logic [7:0]         chn_q  [4];
  logic               byp_q  [3];
  logic               err_q;

  assign chn_ok = {24'd0, bus.din_chn} < NUM_CHN;
  assign accept = bus.din_dv & chn_ok;

  // tap[k] = x[n-k]; a coincident sync sees an already-cleared history
  always_comb begin
    for (int k = 0; k < 8; k++) tap[k] = '0;
    tap[0] = bus.din_dq;
    if (!bus.sync_in) begin
      for (int c = 0; c < NUM_CHN; c++) begin
        if (bus.din_chn == 8'(c)) begin
          for (int k = 0; k < 7; k++) tap[k+1] = hist_q[c][k];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CHN; c++) begin
        for (int k = 0; k < 7; k++) hist_q[c][k] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CHN; c++) begin
        if (accept && bus.din_chn == 8'(c)) begin
          hist_q[c][0] <= bus.din_dq;
          for (int k = 1; k < 7; k++) hist_q[c][k] <= bus.sync_in ? '0 : hist_q[c][k-1];
        end else if (bus.sync_in) begin
          for (int k = 0; k < 7; k++) hist_q[c][k] <= '0;
        end
      end
    end
  end

  // Symmetric pre-add per rail: r=0 is I, r=1 is Q
  always_comb begin
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) begin
        pre_d[r][k] = sx17(tap[k][16*r +: 16]) + sx17(tap[7-k][16*r +: 16]);
      end
    end
  end

  always_comb begin
    for (int r = 0; r < 2; r++) begin
      rnd[r] = (acc_q[r] + 37'sd32768) >>> 16;
      if (rnd[r] > 37'sd32767)       sat[r] = 16'h7fff;
      else if (rnd[r] < -37'sd32768) sat[r] = 16'h8000;
      else                           sat[r] = rnd[r][15:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 2; r++) begin
        for (int k = 0; k < 4; k++) begin
          pre_q[r][k]  <= '0;
          prod_q[r][k] <= '0;
        end
        acc_q[r] <= '0;
      end
      for (int s = 0; s < 3; s++) begin
        dp1_q[s] <= '0;
        byp_q[s] <= 1'b0;
      end
      for (int s = 0; s < 4; s++) begin
        v_q[s]    <= 1'b0;
        sync_q[s] <= 1'b0;
        chn_q[s]  <= '0;
      end
      dp1_out_q <= '0;
      dp2_out_q <= '0;
      err_q     <= 1'b0;
    end else begin
      v_q[0]    <= accept;
      sync_q[0] <= bus.sync_in;
      chn_q[0]  <= bus.din_chn;
      byp_q[0]  <= bypass;
      for (int s = 1; s < 4; s++) begin
        v_q[s]    <= v_q[s-1];
        sync_q[s] <= sync_q[s-1];
        chn_q[s]  <= chn_q[s-1];
      end
      for (int s = 1; s < 3; s++) byp_q[s] <= byp_q[s-1];

      if (accept) begin
        pre_q    <= pre_d;
        dp1_q[0] <= bypass ? bus.din_dq : tap[4];
      end
      if (v_q[0]) begin
        for (int r = 0; r < 2; r++) begin
          for (int k = 0; k < 4; k++) prod_q[r][k] <= 35'(pre_q[r][k]) * 35'(Coeff[k]);
        end
        dp1_q[1] <= dp1_q[0];
      end
      if (v_q[1]) begin
        for (int r = 0; r < 2; r++) begin
          acc_q[r] <= 37'(prod_q[r][0]) + 37'(prod_q[r][1])
                    + 37'(prod_q[r][2]) + 37'(prod_q[r][3]);
        end
        dp1_q[2] <= dp1_q[1];
      end
      if (v_q[2]) begin
        dp1_out_q <= dp1_q[2];
        dp2_out_q <= byp_q[2] ? dp1_q[2] : {sat[1], sat[0]};
      end

      // Set wins over the sync clear
      err_q <= (bus.din_dv & ~chn_ok) | (err_q & ~bus.sync_in);
    end
  end

  assign bus.dout_dp1 = dp1_out_q;
  assign bus.dout_dp2 = dp2_out_q;
  assign bus.dout_dv  = v_q[3];
  assign bus.dout_chn = chn_q[3];
  assign bus.sync_out = sync_q[3];
  assign bus.err_chn  = err_q;

endmodule

// File: tb/tb_prach_hb_interp.sv
// Directed self-checking bench for prach_hb_interp: reset, impulse, DC isolation,
// saturation, sync flush and invalid-channel handling.
module tb_prach_hb_interp;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prach_hb_interp_if bus ();

`ifdef PRACH_HB_INTERP_BYPASS_EN
  logic ctrl_bypass = 1'b0;
`endif

  prach_hb_interp #(.NUM_CHN(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef PRACH_HB_INTERP_BYPASS_EN
    .ctrl_bypass(ctrl_bypass),
`endif
    .bus        (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  int imp_dp2 [9] = '{-192, 768, -1536, 9152, 9152, -1536, 768, -192, 0};
  int sat_in  [8] = '{-32768, 32767, -32768, 32767, 32767, -32768, 32767, -32768};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, step past the edge, leave time at edge+1
  task automatic drive(input logic v, input logic [7:0] c, input logic [31:0] d, input logic s);
    bus.din_dv  = v;
    bus.din_chn = c;
    bus.din_dq  = d;
    bus.sync_in = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    bus.din_dv = 1'b0; bus.din_chn = '0; bus.din_dq = '0; bus.sync_in = 1'b0;

    // Reset held with dv toggling
    for (int i = 0; i < 6; i++) begin
      drive(i[0], 8'd0, 32'h1234_5678, 1'b0);
      chk("rst_dv", {31'd0, bus.dout_dv}, 32'd0);
    end
    chk("rst_dp1", bus.dout_dp1, 32'd0);
    chk("rst_dp2", bus.dout_dp2, 32'd0);
    chk("rst_chn", {24'd0, bus.dout_chn}, 32'd0);
    chk("rst_sync", {31'd0, bus.sync_out}, 32'd0);
    chk("rst_err", {31'd0, bus.err_chn}, 32'd0);

    rst_n = 1'b1;
    drive(1'b0, 8'd0, 32'd0, 1'b0);
    drive(1'b1, 8'd4, 32'h0000_0100, 1'b0);
    drive(1'b0, 8'd0, 32'd0, 1'b0);
    drive(1'b0, 8'd0, 32'd0, 1'b0);
    chk("lat3_dv", {31'd0, bus.dout_dv}, 32'd0);
    drive(1'b0, 8'd0, 32'd0, 1'b0);
    chk("lat4_dv", {31'd0, bus.dout_dv}, 32'd1);
    chk("lat4_chn", {24'd0, bus.dout_chn}, 32'd4);
    chk("lat4_dp1", bus.dout_dp1, 32'd0);
    chk("lat4_dp2", bus.dout_dp2, 32'h0000_fffd);

    // Impulse on chn 0, back-to-back samples
    for (int j = 0; j < 12; j++) begin
      if (j < 9) drive(1'b1, 8'd0, (j == 0) ? 32'h0000_4000 : 32'd0, 1'b0);
      else       drive(1'b0, 8'd0, 32'd0, 1'b0);
      if (j >= 3) begin
        chk("imp_dv", {31'd0, bus.dout_dv}, 32'd1);
        chk("imp_dp2", bus.dout_dp2, {16'h0000, 16'(imp_dp2[j-3])});
        chk("imp_dp1", bus.dout_dp1, (j - 3 == 4) ? 32'h0000_4000 : 32'd0);
      end
    end

    // DC on chn 3 only, round-robin over all channels
    for (int j = 0; j < 67; j++) begin
      if (j < 64) drive(1'b1, 8'(j % 8), (j % 8 == 3) ? 32'h03e8_03e8 : 32'd0, 1'b0);
      else        drive(1'b0, 8'd0, 32'd0, 1'b0);
      if (j >= 3) begin
        chk("dc_dv", {31'd0, bus.dout_dv}, 32'd1);
        chk("dc_chn", {24'd0, bus.dout_chn}, 32'((j - 3) % 8));
        if (j - 3 >= 56) begin
          chk("dc_dp1", bus.dout_dp1, ((j - 3) % 8 == 3) ? 32'h03e8_03e8 : 32'd0);
          chk("dc_dp2", bus.dout_dp2, ((j - 3) % 8 == 3) ? 32'h03e8_03e8 : 32'd0);
        end
      end
    end

    // Saturation on chn 1
    for (int j = 0; j < 11; j++) begin
      if (j < 8) drive(1'b1, 8'd1, {16'h0000, 16'(sat_in[j])}, 1'b0);
      else       drive(1'b0, 8'd0, 32'd0, 1'b0);
      if (j == 3) chk("sat_first_dp2", bus.dout_dp2, 32'h0000_0180);
      if (j == 10) begin
        chk("sat_dp2", bus.dout_dp2, 32'h0000_7fff);
        chk("sat_dp1", bus.dout_dp1, 32'h0000_7fff);
      end
    end
    drive(1'b0, 8'd0, 32'd0, 1'b0);
    chk("hold_dv", {31'd0, bus.dout_dv}, 32'd0);
    chk("hold_dp2", bus.dout_dp2, 32'h0000_7fff);

    // Sync flush on chn 2
    for (int j = 0; j < 11; j++) begin
      if (j < 8) drive(1'b1, 8'd2, 32'h0000_1388, 1'b0);
      else       drive(1'b0, 8'd0, 32'd0, 1'b0);
      if (j == 10) begin
        chk("fill_dp1", bus.dout_dp1, 32'h0000_1388);
        chk("fill_dp2", bus.dout_dp2, 32'h0000_1388);
      end
    end
    drive(1'b0, 8'd0, 32'd0, 1'b1);
    drive(1'b0, 8'd0, 32'd0, 1'b0);
    drive(1'b0, 8'd0, 32'd0, 1'b0);
    chk("sync_lat3", {31'd0, bus.sync_out}, 32'd0);
    drive(1'b0, 8'd0, 32'd0, 1'b0);
    chk("sync_lat4", {31'd0, bus.sync_out}, 32'd1);
    drive(1'b1, 8'd2, 32'd0, 1'b0);
    chk("sync_lat5", {31'd0, bus.sync_out}, 32'd0);
    for (int j = 0; j < 3; j++) drive(1'b0, 8'd0, 32'd0, 1'b0);
    chk("flush_dv", {31'd0, bus.dout_dv}, 32'd1);
    chk("flush_dp1", bus.dout_dp1, 32'd0);
    chk("flush_dp2", bus.dout_dp2, 32'd0);

    // Invalid channel
    drive(1'b1, 8'd9, 32'h1111_1111, 1'b0);
    chk("inv_err_set", {31'd0, bus.err_chn}, 32'd1);
    for (int j = 0; j < 5; j++) begin
      drive(1'b0, 8'd0, 32'd0, 1'b0);
      chk("inv_no_dv", {31'd0, bus.dout_dv}, 32'd0);
    end
    chk("inv_err_sticky", {31'd0, bus.err_chn}, 32'd1);
    drive(1'b0, 8'd0, 32'd0, 1'b1);
    chk("inv_err_clr", {31'd0, bus.err_chn}, 32'd0);
    drive(1'b1, 8'd9, 32'd0, 1'b1);
    chk("inv_err_setwins", {31'd0, bus.err_chn}, 32'd1);
    drive(1'b0, 8'd0, 32'd0, 1'b1);
    chk("inv_err_clr2", {31'd0, bus.err_chn}, 32'd0);
    for (int j = 0; j < 4; j++) drive(1'b0, 8'd0, 32'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
